// File: rtl/hack_pkg.sv
// -----------------------------------------------------------------------------
// hack_pkg
// Shared types and constants for the Hack ROM loader.
//   loader_state_e : frame-parser FSM state encoding
//   ROM_ADDR_W     : instruction ROM address width (15 bits)
//   WORD_W         : instruction word width (16 bits)
//   ROM_WORDS_MAX  : largest ROM the address width can cover (32768 words)
// -----------------------------------------------------------------------------
package hack_pkg;

    localparam int ROM_ADDR_W    = 15;
    localparam int WORD_W        = 16;
    localparam int ROM_WORDS_MAX = 32768;

    typedef enum logic [2:0] {
        ST_LEN_HI  = 3'd0,
        ST_LEN_LO  = 3'd1,
        ST_DATA_HI = 3'd2,
        ST_DATA_LO = 3'd3,
        ST_SUM_HI  = 3'd4,
        ST_SUM_LO  = 3'd5,
        ST_RUN     = 3'd6,
        ST_ERROR   = 3'd7
    } loader_state_e;

endpackage : hack_pkg

// File: rtl/hack_loader_timeout.sv
// -----------------------------------------------------------------------------
// hack_loader_timeout
// Idle-cycle counter for the ROM loader.
//   clk      : system clock
//   reset    : synchronous active-high reset
//   clear    : zero the counter this cycle (byte accepted, restart, or idle state)
//   enable   : count this cycle (a counting state with no accepted byte)
//   expired  : the current cycle is the TIMEOUT_CYCLES-th consecutive idle
//              cycle; if it also ends without a byte, the loader must give up
// -----------------------------------------------------------------------------
module hack_loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // count_q holds the number of idle cycles already completed, so the
    // cycle in which it equals TIMEOUT_CYCLES-1 is the last one allowed.
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST);

endmodule : hack_loader_timeout

// File: rtl/hack_rom_loader.sv
// -----------------------------------------------------------------------------
// hack_rom_loader
// Receives a big-endian program frame from a UART byte stream and writes it
// into the Hack instruction ROM, then releases the CPU from reset.
// Frame: N (2 bytes) | N words (2 bytes each) | checksum (2 bytes, sum mod 2^16)
//   clk        : system clock, rising edge
//   reset      : synchronous active-high reset
//   rx_data    : received byte
//   rx_valid   : byte offered; it is taken on rx_valid && rx_ready
//   rx_ready   : loader is parsing a frame and takes bytes
//   load_req   : one-cycle request to restart loading
//   rom_we     : one-cycle ROM write strobe
//   rom_addr   : ROM write address (word index)
//   rom_wdata  : ROM write data
//   cpu_reset  : held high unless the program loaded successfully
//   done       : program loaded, CPU running
//   error      : load failed
//   dbg_state  : current FSM state
// Handshake: a byte transfers on the rising edge where rx_valid and rx_ready
// are both high; rx_ready is a registered function of the FSM state only, so
// the sender never sees a combinational dependence on its own rx_valid.
// All outputs are registered.
// -----------------------------------------------------------------------------
module hack_rom_loader
    import hack_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int ROM_WORDS      = 32768
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  load_req,
    output logic                  rom_we,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic [WORD_W-1:0]     rom_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output loader_state_e         dbg_state
);

    loader_state_e         state_q,     state_d;
    logic [7:0]            byte_hi_q,   byte_hi_d;
    logic [WORD_W-1:0]     len_q,       len_d;
    logic [WORD_W-1:0]     word_idx_q,  word_idx_d;
    logic [WORD_W-1:0]     sum_q,       sum_d;
    logic                  rx_ready_q,  rx_ready_d;
    logic                  rom_we_q,    rom_we_d;
    logic [ROM_ADDR_W-1:0] rom_addr_q,  rom_addr_d;
    logic [WORD_W-1:0]     rom_wdata_q, rom_wdata_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  done_q,      done_d;
    logic                  error_q,     error_d;

    logic              accept;
    logic              counting;
    logic              tmo_clear;
    logic              tmo_expired;
    logic              timeout_hit;
    logic [WORD_W-1:0] rx_word;
    logic [WORD_W:0]   len_ext;

    assign accept   = rx_valid && rx_ready_q;
    assign rx_word  = {byte_hi_q, rx_data};
    assign len_ext  = {1'b0, rx_word};

    // Only the mid-frame states are supervised; LEN_HI waits forever.
    assign counting = (state_q == ST_LEN_LO)  || (state_q == ST_DATA_HI) ||
                      (state_q == ST_DATA_LO) || (state_q == ST_SUM_HI)  ||
                      (state_q == ST_SUM_LO);

    assign tmo_clear   = load_req || accept || !counting;
    assign timeout_hit = counting && tmo_expired && !accept;

    hack_loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (counting),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        byte_hi_d   = byte_hi_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        sum_d       = sum_q;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;

        if (load_req) begin
            // Restart wins over a byte arriving in the same cycle; that byte is dropped.
            state_d    = ST_LEN_HI;
            word_idx_d = '0;
            sum_d      = '0;
            rom_addr_d = '0;
        end else if (timeout_hit) begin
            state_d = ST_ERROR;
        end else if (accept) begin
            case (state_q)
                ST_LEN_HI: begin
                    byte_hi_d = rx_data;
                    state_d   = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    len_d = rx_word;
                    if (len_ext > (WORD_W + 1)'(ROM_WORDS)) begin
                        state_d = ST_ERROR;
                    end else if (rx_word == '0) begin
                        state_d = ST_SUM_HI;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
                ST_DATA_HI: begin
                    byte_hi_d = rx_data;
                    state_d   = ST_DATA_LO;
                end
                ST_DATA_LO: begin
                    rom_we_d    = 1'b1;
                    rom_addr_d  = word_idx_q[ROM_ADDR_W-1:0];
                    rom_wdata_d = rx_word;
                    sum_d       = sum_q + rx_word;
                    word_idx_d  = word_idx_q + 1'b1;
                    state_d     = ((word_idx_q + 1'b1) == len_q) ? ST_SUM_HI : ST_DATA_HI;
                end
                ST_SUM_HI: begin
                    byte_hi_d = rx_data;
                    state_d   = ST_SUM_LO;
                end
                ST_SUM_LO: begin
                    state_d = (rx_word == sum_q) ? ST_RUN : ST_ERROR;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        // Status outputs are registered images of the next state.
        rx_ready_d  = (state_d != ST_RUN) && (state_d != ST_ERROR);
        cpu_reset_d = (state_d != ST_RUN);
        done_d      = (state_d == ST_RUN);
        error_d     = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LEN_HI;
            byte_hi_q   <= '0;
            len_q       <= '0;
            word_idx_q  <= '0;
            sum_q       <= '0;
            rx_ready_q  <= 1'b1;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_hi_q   <= byte_hi_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            sum_q       <= sum_d;
            rx_ready_q  <= rx_ready_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign rom_we    = rom_we_q;
    assign rom_addr  = rom_addr_q;
    assign rom_wdata = rom_wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;
    assign dbg_state = state_q;

endmodule : hack_rom_loader

// File: tb/tb_hack_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_hack_rom_loader
// Directed frames into hack_rom_loader (TIMEOUT_CYCLES=16). Writes seen on
// the ROM port are logged and compared with a hand-built expected queue.
// -----------------------------------------------------------------------------
module tb_hack_rom_loader;
    import hack_pkg::*;

    localparam int TMO = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        load_req = 1'b0;
    logic        rom_we;
    logic [14:0] rom_addr;
    logic [15:0] rom_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;
    loader_state_e dbg_state;

    hack_rom_loader #(
        .TIMEOUT_CYCLES (TMO),
        .ROM_WORDS      (32768)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .load_req  (load_req),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error),
        .dbg_state (dbg_state)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [30:0] exp_q[$];
    logic [30:0] wr_q[$];
    logic        prev_we = 1'b0;

    always @(negedge clk) begin
        if (rom_we) begin
            wr_q.push_back({rom_addr, rom_wdata});
            check("we_single_cycle", {31'd0, prev_we}, 32'd0);
        end
        prev_we = rom_we;
    end

    task automatic check_writes(input string tag);
        logic [30:0] o;
        logic [30:0] e;
        check({tag, "_wr_count"}, wr_q.size(), exp_q.size());
        while ((wr_q.size() > 0) && (exp_q.size() > 0)) begin
            o = wr_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_wr"}, {1'b0, o}, {1'b0, e});
        end
        wr_q.delete();
        exp_q.delete();
    endtask

    task automatic check_status(input string tag, input logic exp_done, input logic exp_err,
                                input logic exp_cpu_reset, input logic exp_ready);
        check({tag, "_done"},      {31'd0, done},      {31'd0, exp_done});
        check({tag, "_error"},     {31'd0, error},     {31'd0, exp_err});
        check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, exp_cpu_reset});
        check({tag, "_rx_ready"},  {31'd0, rx_ready},  {31'd0, exp_ready});
    endtask

    // ---------------- drivers (called 1ns after a rising edge) ----------------
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Sends the n low bytes of seq, most significant first.
    task automatic send_seq(input int n, input logic [63:0] seq);
        for (int i = 0; i < n; i++) begin
            send_byte(seq[8*(n-1-i) +: 8]);
        end
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check_status("reset", 1'b0, 1'b0, 1'b1, 1'b1);
        check("reset_rom_we",    {31'd0, rom_we}, 32'd0);
        check("reset_rom_addr",  {17'd0, rom_addr}, 32'd0);
        check("reset_rom_wdata", {16'd0, rom_wdata}, 32'd0);
        check("reset_state",     {29'd0, dbg_state}, {29'd0, ST_LEN_HI});

        // Two-word program, good checksum 0x0011+0xEC10=0xEC21
        exp_q.push_back({15'd0, 16'h0011});
        exp_q.push_back({15'd1, 16'hEC10});
        send_seq(4, 64'h0002_0011);
        check("a_we_timing", {31'd0, rom_we}, 32'd1);
        check("a_first_word", {1'b0, rom_addr, rom_wdata}, {1'b0, 15'd0, 16'h0011});
        send_seq(4, 64'hEC10_EC21);
        check_status("a_run", 1'b1, 1'b0, 1'b0, 1'b0);
        check("a_state", {29'd0, dbg_state}, {29'd0, ST_RUN});
        send_byte(8'h55);      // ignored in RUN
        idle(2);
        check_status("a_run_hold", 1'b1, 1'b0, 1'b0, 1'b0);
        check_writes("a");

        // load_req from RUN, then single-word program 0x1234
        pulse_load();
        check_status("b_restart", 1'b0, 1'b0, 1'b1, 1'b1);
        exp_q.push_back({15'd0, 16'h1234});
        send_seq(6, 64'h0001_1234_1234);
        check_status("b_run", 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        check_writes("b");

        // Bad checksum: word is written, then ERROR
        pulse_load();
        exp_q.push_back({15'd0, 16'h0064});
        send_seq(6, 64'h0001_0064_0000);
        check_status("c_err", 1'b0, 1'b1, 1'b1, 1'b0);
        send_seq(2, 64'h0000);  // ignored in ERROR
        idle(2);
        check_status("c_err_hold", 1'b0, 1'b1, 1'b1, 1'b0);
        check_writes("c");

        // Empty program, with a byte dropped under a simultaneous load_req
        pulse_load();
        send_byte(8'h00);
        rx_data  = 8'h01;
        rx_valid = 1'b1;
        pulse_load();
        rx_valid = 1'b0;
        check("d_restart_state", {29'd0, dbg_state}, {29'd0, ST_LEN_HI});
        send_seq(4, 64'h0000_0000);
        check_status("d_run", 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        check_writes("d");

        // Length boundary: 0x8000 is allowed, 0x8001 is rejected
        pulse_load();
        send_seq(2, 64'h8000);
        check_status("e_len_max", 1'b0, 1'b0, 1'b1, 1'b1);
        pulse_load();
        send_seq(2, 64'h8001);
        check_status("e_len_over", 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2);
        check_writes("e");

        // Timeout: 16 idle cycles mid-frame
        pulse_load();
        send_seq(3, 64'h00_0100);
        idle(TMO - 1);
        check("f_no_err_yet", {31'd0, error}, 32'd0);
        idle(1);
        check_status("f_timeout", 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2);
        check_writes("f");

        // 15-cycle gap survives; LEN_HI itself never times out
        pulse_load();
        idle(3 * TMO);
        check_status("g_len_hi_wait", 1'b0, 1'b0, 1'b1, 1'b1);
        send_seq(3, 64'h00_0100);
        repeat (TMO - 1) @(posedge clk);
        #1;
        send_byte(8'h05);
        check("g_gap_no_err", {31'd0, error}, 32'd0);
        exp_q.push_back({15'd0, 16'h0005});
        send_seq(2, 64'h0005);
        check_status("g_run", 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        check_writes("g");

        // Reset mid-frame restarts parsing at LEN_HI
        pulse_load();
        send_seq(3, 64'h00_0100);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check_status("h_reset", 1'b0, 1'b0, 1'b1, 1'b1);
        exp_q.push_back({15'd0, 16'h0007});
        send_seq(6, 64'h0001_0007_0007);
        check_status("h_run", 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        check_writes("h");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hack_rom_loader

// File: doc/hack_rom_loader.md
HACK_ROM_LOADER -- requirements
Module: hack_rom_loader

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1_000_000; maximum idle clocks allowed between bytes inside a frame.
REQ-002 Parameter: ROM_WORDS, default 32768; instruction ROM depth in words.
REQ-003 clk  input  1  system clock; one clock domain; all logic on rising edge.
REQ-004 reset  input  1  reset; synchronous and active-high.
REQ-005 rx_data  input  8  byte from the UART receiver.
REQ-006 rx_valid  input  1  rx_data valid; a byte is accepted when rx_valid && rx_ready.
REQ-007 rx_ready  output  1  loader can accept a byte.
REQ-008 load_req  input  1  single-cycle request to start a new load.
REQ-009 rom_we  output  1  instruction ROM write strobe.
REQ-010 rom_addr  output  15  ROM write address.
REQ-011 rom_wdata  output  16  ROM write data.
REQ-012 cpu_reset  output  1  drives the hack_cpu reset input.
REQ-013 done  output  1  program loaded, CPU running.
REQ-014 error  output  1  load failed; CPU held in reset.

Function
REQ-015 Frame format, big-endian: N (2 bytes, word count), N instruction words (2 bytes each), checksum (2 bytes) = sum of all N words mod 2^16.
REQ-016 FSM states: LEN_HI, LEN_LO, DATA_HI, DATA_LO, SUM_HI, SUM_LO, RUN, ERROR.
REQ-017 Transitions: LEN_HI->LEN_LO->DATA_HI<->DATA_LO->SUM_HI->SUM_LO->RUN|ERROR. Each arrow is taken on byte acceptance. LEN_LO goes directly to SUM_HI when N==0.
REQ-018 rx_ready=1 in LEN_HI through SUM_LO; rx_ready=0 in RUN and ERROR; bytes offered in RUN or ERROR are ignored.
REQ-019 N > ROM_WORDS: on the LEN_LO byte, go to ERROR with no ROM write.
REQ-020 Word write: rom_we is high for exactly one cycle, the cycle after the DATA_LO byte is accepted. rom_wdata = {hi, lo}. rom_addr = word index, starting at 0 and incrementing by 1 after each write.
REQ-021 rom_addr increments without wrapping: the maximum value written is N-1. Across back-to-back bytes, at most one write occurs per 2 cycles.
REQ-022 Checksum accumulates each written word (16-bit, modulo). It is compared on the cycle the SUM_LO byte is accepted. Match -> RUN; mismatch -> ERROR.
REQ-023 RUN: cpu_reset=0 and done=1, both from the first cycle after the SUM_LO byte.
REQ-024 All states other than RUN: cpu_reset=1 and done=0. error=1 exactly while in ERROR.
REQ-025 Timeout: an idle counter runs in LEN_LO..SUM_LO and clears on each accepted byte. It reaches TIMEOUT_CYCLES after that many cycles with no accepted byte; the next cycle is in ERROR. LEN_HI never times out.
REQ-026 load_req in any state -> LEN_HI on the next cycle. It clears the address, checksum and timeout counter, and raises cpu_reset. load_req takes priority over a simultaneous byte, which is dropped.
REQ-027 Words already written before an ERROR remain in ROM; no rollback.

Reset
REQ-028 reset has priority over load_req and rx_valid.
REQ-029 reset -> LEN_HI, rom_we=0, rom_addr=0, rom_wdata=0, checksum=0, counter=0, cpu_reset=1, done=0, error=0, rx_ready=1.
REQ-030 reset mid-frame aborts the load; the bytes that follow are interpreted as a new LEN_HI.

Structure
REQ-031 Package hack_pkg holds the loader state enum, ROM_ADDR_W=15, WORD_W=16 and ROM_WORDS_MAX=32768.
REQ-032 One sub-module, hack_loader_timeout: idle counter with clear and enable inputs and an expired output.
REQ-033 All outputs are registered; no combinational path from rx_data or rx_valid to rom_we.

Verification (bench uses TIMEOUT_CYCLES=16)
REQ-034 After reset: cpu_reset=1, rx_ready=1, rom_we=0, done=0, error=0.
REQ-035 Bytes 00 02 00 11 EC 10 EC 21. Expect two writes: addr 0 / 0x0011, then addr 1 / 0xEC10. Expect done=1 and cpu_reset=0 one cycle after the final byte.
REQ-036 Bytes 00 01 00 64 00 00 (bad checksum). Expect one write, addr 0 / 0x0064. Expect error=1, cpu_reset=1 and rx_ready=0.
REQ-037 Bytes 00 00 00 00. Expect zero writes, then done=1. Bytes 80 01: expect error=1 with no write.
REQ-038 Send 00 01 00, then idle 16 cycles. Expect error=1 on the following cycle and no write. Repeat with a 15-cycle gap: no error.
REQ-039 In RUN, pulse load_req. Expect cpu_reset=1 and done=0 on the next cycle. A new frame 00 01 12 34 12 34 writes addr 0 / 0x1234 and returns to RUN.
